// File: rtl/mem_burst_master.sv
// Burst initiator for the bench memory: write-fill an incrementing pattern, or read it back
// and count mismatches through a READ_LATENCY-deep compare pipeline.
module mem_burst_master #(
  parameter int unsigned ADDR_W       = 16,
  parameter int unsigned DATA_W       = 32,
  parameter int unsigned LEN_W        = 16,
  parameter int unsigned READ_LATENCY = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_op,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [LEN_W-1:0]  cmd_len,
  input  logic [DATA_W-1:0] cmd_seed,
  output logic [ADDR_W-1:0] addr,
  output logic              wr_en,
  output logic              rd_en,
  output logic [DATA_W-1:0] wdata,
  input  logic [DATA_W-1:0] rdata,
  output logic              busy,
  output logic              done,
  output logic [LEN_W-1:0]  err_cnt,
  output logic              err_flag,
  output logic [ADDR_W-1:0] first_err_addr
);

  localparam int unsigned Tail = READ_LATENCY - 1;

  typedef enum logic [2:0] {StIdle, StWrite, StRead, StDrain, StDone} state_e;

  state_e            state_q;
  logic [LEN_W-1:0]  rem_q;
  logic [ADDR_W-1:0] nxt_addr_q;
  logic [DATA_W-1:0] nxt_data_q;
  logic [DATA_W-1:0] rd_exp_q;

  logic [READ_LATENCY-1:0]             pipe_v_q;
  logic [READ_LATENCY-1:0][DATA_W-1:0] pipe_exp_q;
  logic [READ_LATENCY-1:0][ADDR_W-1:0] pipe_addr_q;

  logic inflight;
  logic mismatch;

  // The tail entry retires on the coming edge, so only earlier stages keep DRAIN waiting.
  always_comb begin
    inflight = rd_en;
    for (int unsigned k = 0; k + 1 < READ_LATENCY; k++) begin
      inflight = inflight | pipe_v_q[k];
    end
    mismatch = pipe_v_q[Tail] && (rdata != pipe_exp_q[Tail]);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= StIdle;
      rem_q          <= '0;
      nxt_addr_q     <= '0;
      nxt_data_q     <= '0;
      rd_exp_q       <= '0;
      pipe_v_q       <= '0;
      pipe_exp_q     <= '0;
      pipe_addr_q    <= '0;
      cmd_ready      <= 1'b1;
      busy           <= 1'b0;
      done           <= 1'b0;
      wr_en          <= 1'b0;
      rd_en          <= 1'b0;
      addr           <= '0;
      wdata          <= '0;
      err_cnt        <= '0;
      err_flag       <= 1'b0;
      first_err_addr <= '0;
    end else begin
      // Entry 0 captures the strobe the memory samples on this same edge.
      pipe_v_q[0]    <= rd_en;
      pipe_exp_q[0]  <= rd_exp_q;
      pipe_addr_q[0] <= addr;
      for (int unsigned k = 1; k < READ_LATENCY; k++) begin
        pipe_v_q[k]    <= pipe_v_q[k-1];
        pipe_exp_q[k]  <= pipe_exp_q[k-1];
        pipe_addr_q[k] <= pipe_addr_q[k-1];
      end

      if (mismatch) begin
        if (err_cnt != '1) err_cnt <= err_cnt + 1'b1;
        if (!err_flag) first_err_addr <= pipe_addr_q[Tail];
        err_flag <= 1'b1;
      end

      unique case (state_q)
        StIdle: begin
          if (cmd_valid) begin
            cmd_ready  <= 1'b0;
            busy       <= 1'b1;
            rem_q      <= cmd_len;
            nxt_addr_q <= cmd_addr;
            nxt_data_q <= cmd_seed;
            state_q    <= cmd_op ? StRead : StWrite;
            if (cmd_op) begin
              err_cnt        <= '0;
              err_flag       <= 1'b0;
              first_err_addr <= '0;
            end
          end
        end
        StWrite: begin
          if (rem_q != '0) begin
            wr_en      <= 1'b1;
            addr       <= nxt_addr_q;
            wdata      <= nxt_data_q;
            nxt_addr_q <= nxt_addr_q + 1'b1;
            nxt_data_q <= nxt_data_q + 1'b1;
            rem_q      <= rem_q - 1'b1;
          end else begin
            wr_en   <= 1'b0;
            done    <= 1'b1;
            state_q <= StDone;
          end
        end
        StRead: begin
          if (rem_q != '0) begin
            rd_en      <= 1'b1;
            addr       <= nxt_addr_q;
            rd_exp_q   <= nxt_data_q;
            nxt_addr_q <= nxt_addr_q + 1'b1;
            nxt_data_q <= nxt_data_q + 1'b1;
            rem_q      <= rem_q - 1'b1;
          end else begin
            rd_en <= 1'b0;
            // No beat was ever issued for a zero-length read, so nothing to drain.
            if (rd_en) begin
              state_q <= StDrain;
            end else begin
              done    <= 1'b1;
              state_q <= StDone;
            end
          end
        end
        StDrain: begin
          if (!inflight) begin
            done    <= 1'b1;
            state_q <= StDone;
          end
        end
        StDone: begin
          done      <= 1'b0;
          busy      <= 1'b0;
          cmd_ready <= 1'b1;
          state_q   <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_burst_master.sv
// Bench for mem_burst_master: memory responder, cycle-level behavioural model and
// directed plus randomized command traffic.
module tb_mem_burst_master;
  localparam int RL = 1;

  logic        clk = 1'b0;
  logic        reset, cmd_valid, cmd_ready, cmd_op;
  logic [15:0] cmd_addr, cmd_len, addr, err_cnt, first_err_addr;
  logic [31:0] cmd_seed, wdata, rdata;
  logic        wr_en, rd_en, busy, done, err_flag;

  always #5 clk = ~clk;

  mem_burst_master #(
    .ADDR_W(16), .DATA_W(32), .LEN_W(16), .READ_LATENCY(RL)
  ) dut (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_addr(cmd_addr), .cmd_len(cmd_len), .cmd_seed(cmd_seed), .addr(addr), .wr_en(wr_en),
    .rd_en(rd_en), .wdata(wdata), .rdata(rdata), .busy(busy), .done(done), .err_cnt(err_cnt),
    .err_flag(err_flag), .first_err_addr(first_err_addr)
  );

  // Memory responder: rdata appears RL cycles after the edge that samples rd_en.
  logic [31:0] mem [0:65535];
  logic [31:0] rpipe [RL];
  always @(posedge clk) begin
    if (wr_en) mem[addr] = wdata;
    rpipe[0] <= rd_en ? mem[addr] : 32'hBAD0_BAD0;
    for (int j = 1; j < RL; j++) rpipe[j] <= rpipe[j-1];
  end
  assign rdata = rpipe[RL-1];

  int checks = 0, errors = 0;
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: one command at a time, outputs derived from cycles since acceptance.
  logic [31:0] ref_mem [0:65535];
  int          cyc = 0, acc = 0, n_acc = 0;
  bit          active = 0, started = 0;
  logic        cur_op = 1'b0;
  logic [15:0] cur_a = '0;
  int          cur_l = 0;
  logic [31:0] cur_s = '0;
  bit          mis [0:255];
  int          base_err = 0;
  logic [15:0] base_first = '0, exp_addr = '0;
  logic [31:0] exp_wdata = '0;

  function automatic int dcyc();
    return (!cur_op || cur_l == 0) ? cur_l + 1 : cur_l + RL + 1;
  endfunction

  // Beat i is compared against rdata of cycle i+1+RL, so it is visible from cycle i+2+RL.
  function automatic void model_err(input int k, output int cnt, output logic [15:0] fa);
    cnt = base_err;
    fa  = base_first;
    if (cur_op) begin
      for (int i = 0; i < cur_l; i++) begin
        if (i + 2 + RL <= k && mis[i]) begin
          if (cnt == 0) fa = 16'(cur_a + i);
          cnt++;
        end
      end
    end
  endfunction

  always @(posedge clk) begin : mon
    bit          mready;
    int          c;
    logic [15:0] f;
    mready = !active || (cyc - acc) > dcyc();
    cyc++;
    if (reset) begin
      active = 0; started = 1; base_err = 0; base_first = '0; exp_addr = '0; exp_wdata = '0;
    end else if (started && cmd_valid && mready) begin
      if (active) begin
        model_err(1 << 30, c, f);
        base_err = c; base_first = f;
      end
      cur_op = cmd_op; cur_a = cmd_addr; cur_l = int'(cmd_len); cur_s = cmd_seed;
      acc = cyc; active = 1; n_acc++;
      if (cur_op) begin
        base_err = 0; base_first = '0;
        for (int i = 0; i < cur_l && i < 256; i++)
          mis[i] = ref_mem[16'(cur_a + i)] != 32'(cur_s + i);
      end
    end
  end

  always @(negedge clk) begin : cmp
    int          k, d, ec;
    logic [15:0] ef;
    bit          eb, ew, er;
    if (started) begin
      k = active ? cyc - acc : -1;
      d = dcyc();
      eb = active && k <= d;
      ew = active && !cur_op && k >= 1 && k <= cur_l;
      er = active && cur_op && k >= 1 && k <= cur_l;
      if (ew || er) exp_addr = 16'(cur_a + k - 1);
      if (ew) begin
        exp_wdata = 32'(cur_s + k - 1);
        ref_mem[exp_addr] = exp_wdata;
      end
      if (active) model_err(k, ec, ef);
      else begin ec = base_err; ef = base_first; end
      chk("busy", 64'(busy), 64'(eb));
      chk("cmd_ready", 64'(cmd_ready), 64'(!eb));
      chk("done", 64'(done), 64'(active && k == d));
      chk("wr_en", 64'(wr_en), 64'(ew));
      chk("rd_en", 64'(rd_en), 64'(er));
      chk("addr", 64'(addr), 64'(exp_addr));
      chk("wdata", 64'(wdata), 64'(exp_wdata));
      chk("err_cnt", 64'(err_cnt), 64'(16'(ec)));
      chk("err_flag", 64'(err_flag), 64'(ec != 0));
      chk("first_err_addr", 64'(first_err_addr), 64'(ef));
    end
  end

  task automatic wait_accept(input int n0);
    int n = 0;
    do begin @(posedge clk); #1; n++; end while (n_acc == n0 && n < 400);
    chk("accept_timeout", 64'(n_acc != n0), 64'(1));
  endtask

  task automatic wait_done(output int dc);
    dc = 0;
    while (!done && dc < 400) begin @(posedge clk); #1; dc++; end
    chk("done_timeout", 64'(done), 64'(1));
  endtask

  task automatic send(input logic op, input logic [15:0] a, input logic [15:0] l,
                      input logic [31:0] s, output int dc);
    @(negedge clk);
    cmd_op = op; cmd_addr = a; cmd_len = l; cmd_seed = s; cmd_valid = 1'b1;
    wait_accept(n_acc);
    cmd_valid = 1'b0;
    cmd_op = 1'($urandom); cmd_addr = 16'($urandom); cmd_len = 16'($urandom);
    cmd_seed = $urandom;
    wait_done(dc);
  endtask

  typedef struct {logic [15:0] a; logic [15:0] l; logic [31:0] s;} region_t;
  region_t wq[$];

  initial begin
    int          dc, a1, a2, dcount;
    logic        op;
    logic [15:0] a, l, ix;
    logic [31:0] s;
    region_t     r;
    for (int i = 0; i < 65536; i++) begin mem[i] = '0; ref_mem[i] = '0; end
    reset = 1'b1; cmd_valid = 1'b0; cmd_op = 1'b0; cmd_addr = '0; cmd_len = '0; cmd_seed = '0;
    repeat (3) @(negedge clk);
    reset = 1'b0;

    send(1'b0, 16'h0010, 16'd4, 32'hA5A50000, dc);
    chk("wr4_done_cycle", 64'(dc), 64'(5));
    chk("mem_0013", 64'(mem[16'h0013]), 64'(32'hA5A50003));
    send(1'b1, 16'h0010, 16'd4, 32'hA5A50000, dc);
    chk("rd4_done_cycle", 64'(dc), 64'(6));
    chk("rd4_err_cnt", 64'(err_cnt), 64'(0));
    chk("rd4_err_flag", 64'(err_flag), 64'(0));

    mem[16'h0012] = mem[16'h0012] ^ 32'h1;
    ref_mem[16'h0012] = ref_mem[16'h0012] ^ 32'h1;
    send(1'b1, 16'h0010, 16'd4, 32'hA5A50000, dc);
    chk("corrupt_err_cnt", 64'(err_cnt), 64'(1));
    chk("corrupt_err_flag", 64'(err_flag), 64'(1));
    chk("corrupt_first_addr", 64'(first_err_addr), 64'(16'h0012));

    send(1'b0, 16'hFFFE, 16'd4, 32'hFFFFFFFF, dc);
    chk("wrap_fffe", 64'(mem[16'hFFFE]), 64'(32'hFFFFFFFF));
    chk("wrap_0000", 64'(mem[16'h0000]), 64'(32'h00000001));
    chk("wrap_0001", 64'(mem[16'h0001]), 64'(32'h00000002));
    chk("wrap_err_hold", 64'(err_cnt), 64'(1));

    // Zero-length command, then a read-check offered with cmd_valid held high.
    @(negedge clk);
    cmd_op = 1'b0; cmd_addr = 16'h0300; cmd_len = '0; cmd_seed = 32'h1; cmd_valid = 1'b1;
    wait_accept(n_acc);
    a1 = acc;
    cmd_op = 1'b1; cmd_addr = 16'h0010; cmd_len = 16'd4; cmd_seed = 32'hA5A50000;
    wait_accept(n_acc);
    a2 = acc;
    cmd_valid = 1'b0;
    chk("b2b_accept_gap", 64'(a2 - a1), 64'(3));
    wait_done(dc);
    chk("b2b_rd_done_cycle", 64'(dc), 64'(6));
    chk("b2b_err_cnt", 64'(err_cnt), 64'(1));

    // Reset in cycle 2 of a len-8 write.
    @(negedge clk);
    cmd_op = 1'b0; cmd_addr = 16'h0100; cmd_len = 16'd8; cmd_seed = 32'h12340000;
    cmd_valid = 1'b1;
    wait_accept(n_acc);
    cmd_valid = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    chk("rst_wr_en", 64'(wr_en), 64'(0));
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_err_cnt", 64'(err_cnt), 64'(0));
    dcount = 0;
    repeat (10) begin @(posedge clk); #1; if (done) dcount++; end
    chk("rst_no_done", 64'(dcount), 64'(0));
    chk("rst_beat1", 64'(mem[16'h0101]), 64'(32'h12340001));
    chk("rst_no_beat2", 64'(mem[16'h0102]), 64'(0));
    send(1'b0, 16'h0200, 16'd3, 32'h55, dc);
    chk("post_rst_done_cycle", 64'(dc), 64'(4));

    for (int n = 0; n < 40; n++) begin
      op = 1'($urandom_range(0, 1));
      if (op && wq.size() > 0 && $urandom_range(0, 2) != 0) begin
        r = wq[$urandom_range(0, wq.size() - 1)];
        a = r.a; l = r.l; s = r.s;
        if (l != 0 && $urandom_range(0, 2) == 0) begin
          ix = 16'(a + $urandom_range(0, int'(l) - 1));
          s = s;
          mem[ix] = mem[ix] ^ (32'($urandom) | 32'h1);
          ref_mem[ix] = mem[ix];
        end
      end else begin
        a = ($urandom_range(0, 3) == 0) ? 16'(16'hFFF0 + $urandom_range(0, 15)) : 16'($urandom);
        l = 16'($urandom_range(0, 20));
        s = $urandom;
      end
      send(op, a, l, s, dc);
      if (!op) wq.push_back('{a: a, l: l, s: s});
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end

    repeat (5) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
